// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-writable RAM, lane alignment and a memory-mapped UART transmitter.
// Define DMEM_UART_EN to build in the TX FIFO and UART FSM; without it MMIO reads 0 and uart_txd idles high.
module dmem_ctrl #(
  parameter int ADDR_WIDTH  = 14,
  parameter int CLK_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic        uart_txd,
  output logic        misalign
);

  logic [31:0] ram [2**ADDR_WIDTH];

  logic                  access, is_store, is_load, is_mmio, mis, ram_we;
  logic [1:0]            lane;
  logic [7:0]            oe_span;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            wr_strb;
  logic [31:0]           wr_data;
  logic [31:0]           mmio_rdata;

  logic [31:0] ram_rd_q;
  logic        ld_d, ld_q;
  logic        ld_mmio_d, ld_mmio_q;
  logic [1:0]  ld_lane_d, ld_lane_q;
  logic [3:0]  ld_oe_d, ld_oe_q;
  logic [31:0] mmio_rd_d, mmio_rd_q;
  logic [31:0] rdata_hold_d, rdata_hold_q;
  logic        misalign_d, misalign_q;
  logic [31:0] ld_word, ld_mask, ld_data;

  // NOTE: every combinational output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    access   = |mem_oe;
    is_store = access && (|mem_we);
    is_load  = access && !(|mem_we);
    is_mmio  = mem_addr[31];
    lane     = mem_addr[1:0];
    word_idx = mem_addr[2 +: ADDR_WIDTH];
    oe_span  = {4'b0000, mem_oe} << lane;
    mis      = access && (|oe_span[7:4]);
    wr_strb  = mem_we << lane;
    wr_data  = mem_wdata << {lane, 3'b000};
    ram_we   = is_store && !is_mmio && !mis;
  end

  // NOTE: the RAM has no reset so it can map onto block RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) ram[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (is_load && !is_mmio) ram_rd_q <= ram[word_idx];
  end

  // Load data is realigned and masked to the requested lanes after the registered read.
  always_comb begin
    ld_d         = is_load;
    ld_mmio_d    = is_load ? is_mmio    : ld_mmio_q;
    ld_lane_d    = is_load ? lane       : ld_lane_q;
    ld_oe_d      = is_load ? mem_oe     : ld_oe_q;
    mmio_rd_d    = is_load ? mmio_rdata : mmio_rd_q;
    misalign_d   = mis;
    ld_word      = ld_mmio_q ? mmio_rd_q : ram_rd_q;
    ld_mask      = '0;
    for (int i = 0; i < 4; i++) ld_mask[8*i +: 8] = {8{ld_oe_q[i]}};
    ld_data      = (ld_word >> {ld_lane_q, 3'b000}) & ld_mask;
    mem_rdata    = ld_q ? ld_data : rdata_hold_q;
    rdata_hold_d = mem_rdata;
    mem_valid    = ld_q;
    misalign     = misalign_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q         <= 1'b0;
      ld_mmio_q    <= 1'b0;
      ld_lane_q    <= 2'd0;
      ld_oe_q      <= 4'd0;
      mmio_rd_q    <= 32'd0;
      rdata_hold_q <= 32'd0;
      misalign_q   <= 1'b0;
    end else begin
      ld_q         <= ld_d;
      ld_mmio_q    <= ld_mmio_d;
      ld_lane_q    <= ld_lane_d;
      ld_oe_q      <= ld_oe_d;
      mmio_rd_q    <= mmio_rd_d;
      rdata_hold_q <= rdata_hold_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef DMEM_UART_EN
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
  localparam int          BW          = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_PER_BIT - 1);

  tx_state_e   state_d, state_q;
  logic [BW-1:0] baud_d, baud_q;
  logic [2:0]  bit_d, bit_q;
  logic [7:0]  shift_d, shift_q;
  logic [7:0]  fifo_d [2];
  logic [7:0]  fifo_q [2];
  logic        wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [1:0]  fifo_cnt_d, fifo_cnt_q;
  logic        tx_wr, push, tx_pop, baud_done, fifo_nonempty, tx_active;

  always_comb begin
    tx_wr         = is_store && !mis && (mem_addr == TXDATA_ADDR);
    push          = tx_wr && (fifo_cnt_q != 2'd2);
    fifo_nonempty = (fifo_cnt_q != 2'd0);
    // One free slot is promised for whatever the core issues next cycle.
    mem_ready     = ({1'b0, fifo_cnt_q} + {2'b00, tx_wr}) <= 3'd1;
    mmio_rdata    = '0;
    if (is_mmio && (mem_addr == STATUS_ADDR)) mmio_rdata = {29'd0, tx_active, fifo_cnt_q};
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = mem_wdata[7:0];
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (tx_pop) rd_ptr_d = ~rd_ptr_q;
    if (push && !tx_pop)      fifo_cnt_d = fifo_cnt_q + 2'd1;
    else if (!push && tx_pop) fifo_cnt_d = fifo_cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_pop    = 1'b0;
    baud_done = (baud_q == '0);
    case (state_q)
      TX_IDLE: begin
        if (fifo_nonempty) begin
          tx_pop  = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = BAUD_MAX;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (fifo_nonempty) begin
            tx_pop  = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            baud_d  = BAUD_MAX;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_txd  = 1'b1;
    tx_active = 1'b0;
    case (state_q)
      TX_START: begin
        uart_txd  = 1'b0;
        tx_active = 1'b1;
      end
      TX_DATA: begin
        uart_txd  = shift_q[0];
        tx_active = 1'b1;
      end
      TX_STOP: tx_active = 1'b1;
      default: ;
    endcase
  end
`else
  logic addr_unused;

  assign mmio_rdata  = '0;
  assign mem_ready   = 1'b1;
  assign uart_txd    = 1'b1;
  assign addr_unused = ^mem_addr[30:ADDR_WIDTH+2];
`endif

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller on the processor's load/store port. It consumes the core's registered `mem_*` requests and returns `mem_rdata`, `mem_valid` and `mem_ready`. It holds a byte-writable data RAM and a memory-mapped UART transmitter with a 2-entry TX FIFO, and it performs byte-lane alignment between the core's right-justified data and word-organised storage.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: RAM word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words.
- `CLK_PER_BIT`, 868: UART bit period in clocks, valid range ≥2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `mem_addr`  in  32: byte address.
- `mem_oe`  in  4: right-justified lane mask. Nonzero means access.
- `mem_wdata`  in  32: right-justified store data.
- `mem_we`  in  4: right-justified write mask. Nonzero means store.
- `mem_rdata`  out  32: load data, right-justified.
- `mem_valid`  out  1: load data valid, one-cycle pulse.
- `mem_ready`  out  1: the core may issue an access next cycle.
- `uart_txd`  out  1: serial output, idles high.
- `misalign`  out  1: one-cycle pulse on a misaligned access.

## Operation
- Request decode happens in every cycle in which `mem_oe` is nonzero. A request is a store if `mem_we` is nonzero, otherwise a load.
- Address map, decoded on `mem_addr[31]`:
  - 0: RAM, word index `mem_addr[2+:ADDR_WIDTH]`.
  - 1: MMIO.
    - 0x80000000 TXDATA: write-only, pushes `wdata[7:0]`.
    - 0x80000004 STATUS: read-only. [1:0] FIFO count, [2] transmitter active, rest 0.
    - Other MMIO addresses read 0 and ignore writes.
- Lane handling, with `lane = mem_addr[1:0]`:
  - Store strobes = `mem_we << lane`.
  - Store data = `mem_wdata << 8*lane`.
  - Load word is returned as `word >> 8*lane`, zero-filled; the core sign-extends.
- Misaligned access is any mask that crosses the word boundary (`mem_oe << lane` overflows 4 bits).
  - Stores: dropped.
  - Loads: still return data with `mem_valid`.
  - `misalign` pulses in the following cycle.
- TX FIFO: 2 entries. `mem_ready` = (count + TXDATA-write-this-cycle) ≤ 1 (combinational). This guarantees one free slot for any access the core issues in the next cycle.
- A TXDATA write to a full FIFO is dropped. This is only reachable if the core ignores `mem_ready`.
- UART FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - In IDLE with the FIFO nonempty: pop, go to START.
  - At the end of STOP with the FIFO nonempty: pop, go directly to START (no gap).
  - Each state/bit lasts exactly CLK_PER_BIT cycles, counted by an internal down-counter.
- A push and a pop in the same cycle leave the count unchanged.

## Timing
- Reset values:
  - `mem_rdata`=0, `mem_valid`=0, `mem_ready`=1, `uart_txd`=1, `misalign`=0.
  - FIFO empty, FSM IDLE.
  - RAM contents are not reset.
- Load issued in cycle N: `mem_rdata`/`mem_valid` are registered and valid in cycle N+1 for both RAM and MMIO. `mem_valid`=0 for stores and idle cycles. `mem_rdata` holds its last value otherwise.
- Store in cycle N: RAM updated at the end of N. A load of the same word in N+1 sees the new data.
- TXDATA push in N: count increments in N+1. If the FSM is IDLE, the pop happens in N+1 and the start bit (`uart_txd`=0) appears in N+2.
- `mem_ready` responds in the same cycle to a TXDATA write and to the FIFO count.
- Asserting `rst` mid-frame takes effect immediately:
  - `uart_txd` goes to 1 and the FIFO empties.
  - An in-flight load produces no `mem_valid`.

## Configuration
- `DMEM_UART_EN` defined: UART FIFO and FSM are compiled in as described.
- `DMEM_UART_EN` undefined:
  - All MMIO reads return 0 and writes are ignored.
  - `uart_txd` is tied to 1.
  - `mem_ready` is tied to 1.
  - The RAM path is unchanged.

## Test plan
- SB 0xA5 at 0x00000003, then LW 0x00000000: strobe 4'b1000 written; load returns 0xA5xxxxxx with only byte 3 changed; `mem_valid` exactly 1 cycle after the load.
- SW 0x80FF1234 at 0x10, then LH at 0x12: returns 0x000080FF; LB at 0x11 returns 0x00000012.
- SH at 0x00000003 and LW at 0x00000002: no RAM change; `misalign` pulses once per access; the load still gives `mem_valid`.
- CLK_PER_BIT=4, write 0x55 to TXDATA: start bit 2 cycles later; `uart_txd` sequence 0,1,0,1,0,1,0,1,0,1, each 4 cycles; STATUS reads 0x4 mid-frame and 0x0 after.
- Three back-to-back TXDATA writes 0x01, 0x02, 0x03: `mem_ready` drops in the cycle count+push reaches 2; the third write is issued only after `mem_ready` returns; frames are contiguous with no idle gap; all three bytes are observed.
- Assert `rst` during DATA bit 3: `uart_txd`=1 immediately; STATUS=0 after release; `mem_ready`=1.
